rep_frame_receiver: RTL and testbench

Parametrised successor to the single-channel receiver/decoder path. Accepts REP-bit repetition-coded channel symbols, majority-decodes each to one bit, hunts for a sync word, then assembles a fixed-length payload frame. Completed frames, each with its corrected-symbol count, are buffered in a small FIFO with a valid/ready output handshake. Sits between the channel model and the sink/checker logic, on one clock.

---
 rtl/rep_frame_receiver_if.sv | 27 ++
 rtl/rep_frame_receiver.sv | 152 +++++++++++++++
 tb/tb_rep_frame_receiver.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rep_frame_receiver_if.sv
// Channel-side symbol input and sink-side frame handshake of rep_frame_receiver.
// The slave modport is the receiver; the master modport is the channel/sink side.
interface rep_frame_receiver_if #(
    parameter int unsigned REP       = 3,
    parameter int unsigned PAYLOAD_W = 8
);
    localparam int unsigned CW = $clog2(PAYLOAD_W + 1);

    logic [REP-1:0]       data_i;
    logic                 in_valid;
    logic [PAYLOAD_W-1:0] frame_o;
    logic [CW-1:0]        corr_o;
    logic                 frame_valid;
    logic                 frame_ready;
    logic                 overflow;
    logic                 locked;

    modport master (
        output data_i, in_valid, frame_ready,
        input  frame_o, corr_o, frame_valid, overflow, locked
    );

    modport slave (
        input  data_i, in_valid, frame_ready,
        output frame_o, corr_o, frame_valid, overflow, locked
    );
endinterface

// File: rtl/rep_frame_receiver.sv
// Repetition-code majority decoder, sync hunter and payload framer feeding a
// first-word-fall-through frame FIFO with a valid/ready output.
module rep_frame_receiver #(
    parameter int unsigned         REP        = 3,
    parameter int unsigned         SYNC_W     = 8,
    parameter logic [SYNC_W-1:0]   SYNC_WORD  = 8'hA5,
    parameter int unsigned         PAYLOAD_W  = 8,
    parameter int unsigned         FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    rep_frame_receiver_if.slave    bus
);
    localparam int unsigned CW = $clog2(PAYLOAD_W + 1);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned OW = $clog2(REP + 1);
    localparam int unsigned EW = PAYLOAD_W + CW;

    typedef enum logic {HUNT, PAYLOAD} state_e;

    state_e               state_q, state_d;
    logic [SYNC_W-1:0]    hist_q, hist_d;
    logic [PAYLOAD_W-1:0] pay_q, pay_d;
    logic [CW-1:0]        bcnt_q, bcnt_d;
    logic [CW-1:0]        ccnt_q, ccnt_d;
    logic [EW-1:0]        mem_q [FIFO_DEPTH];
    logic [EW-1:0]        mem_d [FIFO_DEPTH];
    logic [AW:0]          wptr_q, wptr_d;
    logic [AW:0]          rptr_q, rptr_d;
    logic                 valid_q, valid_d;
    logic                 ovf_q, ovf_d;

    logic [OW-1:0]        ones;
    logic                 bit_dec;
    logic                 sym_corr;
    logic [SYNC_W-1:0]    hist_shift;
    logic [PAYLOAD_W-1:0] pay_shift;
    logic [CW-1:0]        ccnt_inc;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic [EW-1:0]        rd_entry;

    always_comb begin
        ones = '0;
        for (int unsigned i = 0; i < REP; i++) begin
            ones = ones + OW'(bus.data_i[i]);
        end
        bit_dec    = (ones > OW'(REP / 2));
        sym_corr   = (bus.data_i != '0) && (bus.data_i != '1);
        hist_shift = {hist_q[SYNC_W-2:0], bit_dec};
        pay_shift  = {pay_q[PAYLOAD_W-2:0], bit_dec};
        ccnt_inc   = ccnt_q + CW'(sym_corr);
    end

    // Framing: hist only shifts while hunting and is zeroed after each frame,
    // so payload bits can never contribute to the next sync match.
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        pay_d   = pay_q;
        bcnt_d  = bcnt_q;
        ccnt_d  = ccnt_q;
        push    = 1'b0;
        if (bus.in_valid) begin
            case (state_q)
                HUNT: begin
                    hist_d = hist_shift;
                    if (hist_shift == SYNC_WORD) begin
                        state_d = PAYLOAD;
                        bcnt_d  = '0;
                        ccnt_d  = '0;
                    end
                end
                PAYLOAD: begin
                    pay_d  = pay_shift;
                    bcnt_d = bcnt_q + CW'(1);
                    ccnt_d = ccnt_inc;
                    if (bcnt_q == CW'(PAYLOAD_W - 1)) begin
                        push    = 1'b1;
                        state_d = HUNT;
                        hist_d  = '0;
                        bcnt_d  = '0;
                        ccnt_d  = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_comb begin
        empty  = (wptr_q == rptr_q);
        full   = ((wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}});
        pop    = !empty && bus.frame_ready;
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        ovf_d  = 1'b0;
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        if (push) begin
            if (full && !pop) begin
                ovf_d = 1'b1;
            end else begin
                mem_d[wptr_q[AW-1:0]] = {pay_shift, ccnt_inc};
                wptr_d                = wptr_q + 1'b1;
            end
        end
        valid_d = (wptr_d != rptr_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= HUNT;
            hist_q  <= '0;
            pay_q   <= '0;
            bcnt_q  <= '0;
            ccnt_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            pay_q   <= pay_d;
            bcnt_q  <= bcnt_d;
            ccnt_q  <= ccnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            mem_q   <= mem_d;
        end
    end

    always_comb begin
        rd_entry        = mem_q[rptr_q[AW-1:0]];
        bus.frame_o     = valid_q ? rd_entry[EW-1:CW] : '0;
        bus.corr_o      = valid_q ? rd_entry[CW-1:0] : '0;
        bus.frame_valid = valid_q;
        bus.overflow    = ovf_q;
        bus.locked      = (state_q == PAYLOAD);
    end
endmodule

// File: tb/tb_rep_frame_receiver.sv
// Directed bench for rep_frame_receiver: sync/payload framing, correction
// counting, FIFO full/overflow behaviour and asynchronous reset.
module tb_rep_frame_receiver;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    logic [11:0] pop_q [$];
    int          vcyc;
    int          ovf_cnt;

    rep_frame_receiver_if #(.REP(3), .PAYLOAD_W(8)) bus ();

    rep_frame_receiver #(
        .REP        (3),
        .SYNC_W     (8),
        .SYNC_WORD  (8'hA5),
        .PAYLOAD_W  (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Mid-cycle observer: records every accepted pop and the overflow/valid cycles.
    always @(negedge clk) begin
        if (bus.frame_valid && bus.frame_ready) pop_q.push_back({bus.frame_o, bus.corr_o});
        if (bus.overflow) ovf_cnt++;
        if (bus.frame_valid) vcyc++;
    end

    task automatic clear_obs();
        pop_q.delete();
        vcyc    = 0;
        ovf_cnt = 0;
    endtask

    task automatic send_sym(input logic [2:0] sym, input int gap);
        bus.data_i   = sym;
        bus.in_valid = 1'b1;
        @(posedge clk); #2;
        bus.in_valid = 1'b0;
        bus.data_i   = '0;
        repeat (gap) begin @(posedge clk); #2; end
    endtask

    task automatic send_bit(input logic b, input int gap);
        send_sym(b ? 3'b111 : 3'b000, gap);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int i = 7; i >= 0; i--) send_bit(b[i], gap);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.data_i = '0; bus.in_valid = 1'b0; bus.frame_ready = 1'b0;
        clear_obs();
        repeat (3) @(posedge clk);
        #2;
        checks += 5;
        if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.frame_valid); end
        if (bus.overflow !== 1'b0)    begin errors++; $display("FAIL reset_ovf got=%b exp=0", bus.overflow); end
        if (bus.locked !== 1'b0)      begin errors++; $display("FAIL reset_locked got=%b exp=0", bus.locked); end
        if (bus.frame_o !== 8'h00)    begin errors++; $display("FAIL reset_frame got=%h exp=00", bus.frame_o); end
        if (bus.corr_o !== 4'd0)      begin errors++; $display("FAIL reset_corr got=%0d exp=0", bus.corr_o); end
        reset = 1'b1;
        idle(1);
    endtask

    task automatic test_clean_frame();
        logic [7:0] sw;
        logic [7:0] pl;
        sw = 8'hA5; pl = 8'h3C;
        clear_obs();
        bus.frame_ready = 1'b1;
        for (int i = 7; i >= 1; i--) send_bit(sw[i], 0);
        checks++;
        if (bus.locked !== 1'b0) begin errors++; $display("FAIL clean_prelock got=%b exp=0", bus.locked); end
        send_bit(sw[0], 0);
        checks++;
        if (bus.locked !== 1'b1) begin errors++; $display("FAIL clean_lock got=%b exp=1", bus.locked); end
        for (int i = 7; i >= 1; i--) send_bit(pl[i], 0);
        checks++;
        if (bus.locked !== 1'b1) begin errors++; $display("FAIL clean_lock_held got=%b exp=1", bus.locked); end
        send_bit(pl[0], 0);
        checks += 4;
        if (bus.locked !== 1'b0)      begin errors++; $display("FAIL clean_unlock got=%b exp=0", bus.locked); end
        if (bus.frame_valid !== 1'b1) begin errors++; $display("FAIL clean_latency got=%b exp=1", bus.frame_valid); end
        if (bus.frame_o !== 8'h3C)    begin errors++; $display("FAIL clean_head got=%h exp=3c", bus.frame_o); end
        if (bus.corr_o !== 4'd0)      begin errors++; $display("FAIL clean_head_corr got=%0d exp=0", bus.corr_o); end
        idle(3);
        checks += 2;
        if (pop_q.size() !== 1) begin errors++; $display("FAIL clean_count got=%0d exp=1", pop_q.size()); end
        else if (pop_q[0] !== {8'h3C, 4'd0}) begin errors++; $display("FAIL clean_entry got=%h exp=3c0", pop_q[0]); end
        if (vcyc !== 1) begin errors++; $display("FAIL clean_valid_cycles got=%0d exp=1", vcyc); end
    endtask

    task automatic test_corrections();
        logic [7:0] sw;
        logic [7:0] pl;
        logic [2:0] sym;
        sw = 8'hA5; pl = 8'h3C;
        clear_obs();
        send_sym(3'b101, 0);
        for (int i = 6; i >= 0; i--) send_bit(sw[i], 0);
        checks++;
        if (bus.locked !== 1'b1) begin errors++; $display("FAIL corr_sync_lock got=%b exp=1", bus.locked); end
        // payload symbol 2 (a 1) sent as 110, last symbol 7 (a 0) sent as 001
        for (int k = 0; k < 8; k++) begin
            sym = pl[7-k] ? 3'b111 : 3'b000;
            if (k == 2) sym = 3'b110;
            if (k == 7) sym = 3'b001;
            send_sym(sym, 0);
        end
        idle(3);
        checks++;
        if (pop_q.size() !== 1) begin errors++; $display("FAIL corr_count got=%0d exp=1", pop_q.size()); end
        else if (pop_q[0] !== {8'h3C, 4'd2}) begin errors++; $display("FAIL corr_entry got=%h exp=3c2", pop_q[0]); end
    endtask

    task automatic test_hunt_garbage();
        clear_obs();
        send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
        send_byte(8'hA5, 0);
        checks++;
        if (bus.locked !== 1'b1) begin errors++; $display("FAIL garbage_lock got=%b exp=1", bus.locked); end
        send_byte(8'h5A, 0);
        idle(3);
        checks++;
        if (pop_q.size() !== 1) begin errors++; $display("FAIL garbage_count got=%0d exp=1", pop_q.size()); end
        else if (pop_q[0] !== {8'h5A, 4'd0}) begin errors++; $display("FAIL garbage_entry got=%h exp=5a0", pop_q[0]); end
    endtask

    task automatic test_payload_no_lock();
        clear_obs();
        // Payload tail 1010010 plus one fresh 1 would spell A5 if hist kept shifting.
        send_byte(8'hA5, 0);
        send_byte(8'h52, 0);
        send_bit(1'b1, 0);
        checks++;
        if (bus.locked !== 1'b0) begin errors++; $display("FAIL nolock_tail got=%b exp=0", bus.locked); end
        send_byte(8'h00, 0);
        idle(3);
        checks += 2;
        if (bus.locked !== 1'b0) begin errors++; $display("FAIL nolock_end got=%b exp=0", bus.locked); end
        if (pop_q.size() !== 1) begin errors++; $display("FAIL nolock_count got=%0d exp=1", pop_q.size()); end
        else if (pop_q[0] !== {8'h52, 4'd0}) begin errors++; $display("FAIL nolock_entry got=%h exp=520", pop_q[0]); end
    endtask

    task automatic test_gaps();
        logic [15:0] bits;
        bits = {8'hA5, 8'h3C};
        clear_obs();
        for (int i = 15; i >= 0; i--) send_bit(bits[i], (i % 3) + 1);
        idle(3);
        checks++;
        if (pop_q.size() !== 1) begin errors++; $display("FAIL gaps_count got=%0d exp=1", pop_q.size()); end
        else if (pop_q[0] !== {8'h3C, 4'd0}) begin errors++; $display("FAIL gaps_entry got=%h exp=3c0", pop_q[0]); end
    endtask

    task automatic test_fifo_full();
        clear_obs();
        bus.frame_ready = 1'b0;
        for (int f = 1; f <= 4; f++) begin send_byte(8'hA5, 0); send_byte(8'(f), 0); end
        checks += 2;
        if (bus.frame_valid !== 1'b1) begin errors++; $display("FAIL full_valid got=%b exp=1", bus.frame_valid); end
        if (ovf_cnt !== 0) begin errors++; $display("FAIL full_early_ovf got=%0d exp=0", ovf_cnt); end
        send_byte(8'hA5, 0); send_byte(8'h05, 0);
        idle(2);
        checks += 3;
        if (ovf_cnt !== 1) begin errors++; $display("FAIL full_ovf_pulses got=%0d exp=1", ovf_cnt); end
        if (bus.frame_o !== 8'h01) begin errors++; $display("FAIL full_head got=%h exp=01", bus.frame_o); end
        if (pop_q.size() !== 0) begin errors++; $display("FAIL full_no_pop got=%0d exp=0", pop_q.size()); end
        bus.frame_ready = 1'b1;
        idle(6);
        checks += 2;
        if (pop_q.size() !== 4) begin errors++; $display("FAIL full_drain_count got=%0d exp=4", pop_q.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (pop_q[i] !== {8'(i + 1), 4'd0}) begin errors++; $display("FAIL full_drain_%0d got=%h exp=%h", i, pop_q[i], {8'(i + 1), 4'd0}); end
            end
        end
        if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL full_empty got=%b exp=0", bus.frame_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pl;
        pl = 8'h05;
        clear_obs();
        bus.frame_ready = 1'b0;
        for (int f = 1; f <= 4; f++) begin send_byte(8'hA5, 0); send_byte(8'(f), 0); end
        send_byte(8'hA5, 0);
        for (int i = 7; i >= 1; i--) send_bit(pl[i], 0);
        bus.frame_ready = 1'b1;
        send_bit(pl[0], 0);
        bus.frame_ready = 1'b0;
        idle(2);
        checks += 2;
        if (ovf_cnt !== 0) begin errors++; $display("FAIL b2b_ovf got=%0d exp=0", ovf_cnt); end
        if (pop_q.size() !== 1) begin errors++; $display("FAIL b2b_first_pop got=%0d exp=1", pop_q.size()); end
        bus.frame_ready = 1'b1;
        idle(6);
        checks++;
        if (pop_q.size() !== 5) begin errors++; $display("FAIL b2b_drain_count got=%0d exp=5", pop_q.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (pop_q[i] !== {8'(i + 1), 4'd0}) begin errors++; $display("FAIL b2b_entry_%0d got=%h exp=%h", i, pop_q[i], {8'(i + 1), 4'd0}); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] pl;
        pl = 8'h77;
        clear_obs();
        bus.frame_ready = 1'b0;
        send_byte(8'hA5, 0); send_byte(8'h11, 0);
        send_byte(8'hA5, 0);
        for (int i = 7; i >= 4; i--) send_bit(pl[i], 0);
        checks += 2;
        if (bus.locked !== 1'b1) begin errors++; $display("FAIL rmid_pre_locked got=%b exp=1", bus.locked); end
        if (bus.frame_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid got=%b exp=1", bus.frame_valid); end
        reset = 1'b0;
        #1;
        checks += 5;
        if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b exp=0", bus.frame_valid); end
        if (bus.frame_o !== 8'h00)    begin errors++; $display("FAIL rmid_frame got=%h exp=00", bus.frame_o); end
        if (bus.corr_o !== 4'd0)      begin errors++; $display("FAIL rmid_corr got=%0d exp=0", bus.corr_o); end
        if (bus.locked !== 1'b0)      begin errors++; $display("FAIL rmid_locked got=%b exp=0", bus.locked); end
        if (bus.overflow !== 1'b0)    begin errors++; $display("FAIL rmid_ovf got=%b exp=0", bus.overflow); end
        @(posedge clk); #2;
        reset = 1'b1;
        bus.frame_ready = 1'b1;
        clear_obs();
        send_byte(8'hA5, 0); send_byte(8'h77, 0);
        idle(3);
        checks++;
        if (pop_q.size() !== 1) begin errors++; $display("FAIL rmid_count got=%0d exp=1", pop_q.size()); end
        else if (pop_q[0] !== {8'h77, 4'd0}) begin errors++; $display("FAIL rmid_entry got=%h exp=770", pop_q[0]); end
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_corrections();
        test_hunt_garbage();
        test_payload_no_lock();
        test_gaps();
        test_fifo_full();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
